// File: rtl/aplic_msi_write_arbiter.sv
// aplic_msi_write_arbiter: round-robin sharing of one single-beat MSI write port among APLIC domains
module aplic_msi_write_arbiter #(
    parameter int NR_DOMAINS = 2,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int B_TIMEOUT  = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NR_DOMAINS-1:0]        i_msi_valid,
    input  logic [NR_DOMAINS*ADDR_W-1:0] i_msi_addr,
    input  logic [NR_DOMAINS*DATA_W-1:0] i_msi_data,
    output logic [NR_DOMAINS-1:0]        o_msi_ready,
    output logic [NR_DOMAINS-1:0]        o_msi_done,
    output logic [NR_DOMAINS-1:0]        o_msi_err,
    output logic                         o_aw_valid,
    output logic [ADDR_W-1:0]            o_aw_addr,
    input  logic                         i_aw_ready,
    output logic                         o_w_valid,
    output logic [DATA_W-1:0]            o_w_data,
    input  logic                         i_w_ready,
    input  logic                         i_b_valid,
    input  logic [1:0]                   i_b_resp,
    output logic                         o_b_ready,
    output logic                         o_busy
);
    localparam int PW = NR_DOMAINS > 1 ? $clog2(NR_DOMAINS) : 1;
    localparam int CW = $clog2(B_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           rr_q, rr_d, g_q, g_d, gsel;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NR_DOMAINS-1:0]   done_q, done_d, err_q, err_d;
    logic                    found;
    int                      j;

    // first valid requester at or after the round-robin pointer, wrapping
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        j     = 0;
        for (int k = 0; k < NR_DOMAINS; k++) begin
            j = int'(rr_q) + k;
            if (j >= NR_DOMAINS) j = j - NR_DOMAINS;
            if (!found && i_msi_valid[PW'(j)]) begin
                found = 1'b1;
                gsel  = PW'(j);
            end
        end
    end

    assign o_msi_ready = (state_q == IDLE && found && !i_rst) ? (NR_DOMAINS'(1) << gsel) : '0;
    assign o_aw_valid  = state_q == SEND && !aw_sent_q;
    assign o_w_valid   = state_q == SEND && !w_sent_q;
    assign o_aw_addr   = addr_q;
    assign o_w_data    = data_q;
    assign o_b_ready   = !i_rst && state_q != SEND;
    assign o_busy      = state_q != IDLE;
    assign o_msi_done  = done_q;
    assign o_msi_err   = err_q;

    // next-state: grant and capture, independent AW/W tracking, B wait with timeout
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        g_d       = g_q;
        addr_d    = addr_q;
        data_d    = data_q;
        aw_sent_d = aw_sent_q;
        w_sent_d  = w_sent_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        err_d     = '0;
        case (state_q)
            IDLE: if (found) begin
                state_d   = SEND;
                g_d       = gsel;
                rr_d      = (gsel == PW'(NR_DOMAINS - 1)) ? '0 : gsel + PW'(1);
                addr_d    = i_msi_addr[int'(gsel)*ADDR_W +: ADDR_W];
                data_d    = i_msi_data[int'(gsel)*DATA_W +: DATA_W];
                aw_sent_d = 1'b0;
                w_sent_d  = 1'b0;
            end
            SEND: begin
                aw_sent_d = aw_sent_q || (o_aw_valid && i_aw_ready);
                w_sent_d  = w_sent_q || (o_w_valid && i_w_ready);
                if (aw_sent_d && w_sent_d) begin
                    state_d = WAIT_B;
                    cnt_d   = '0;
                end
            end
            WAIT_B: if (i_b_valid || cnt_q == CW'(B_TIMEOUT - 1)) begin
                state_d = IDLE;
                done_d  = NR_DOMAINS'(1) << g_q;
                err_d   = (!i_b_valid || i_b_resp != 2'b00) ? done_d : '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset abandons any transaction without a done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
            cnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            g_q       <= g_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            aw_sent_q <= aw_sent_d;
            w_sent_q  <= w_sent_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_aplic_msi_write_arbiter.sv
// tb_aplic_msi_write_arbiter: directed checks of grant order, split handshakes, errors, timeout and reset
module tb_aplic_msi_write_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   msi_valid = '0;
    logic [127:0] msi_addr = '0;
    logic [63:0]  msi_data = '0;
    logic [1:0]   msi_ready, msi_done, msi_err;
    logic         aw_valid, w_valid, b_ready, busy;
    logic [63:0]  aw_addr;
    logic [31:0]  w_data;
    logic         aw_ready = 1'b1, w_ready = 1'b1, b_valid = 1'b0;
    logic [1:0]   b_resp = 2'b00;
    int           n_cmp = 0;
    int           n_err = 0;

    aplic_msi_write_arbiter #(.NR_DOMAINS(2), .ADDR_W(64), .DATA_W(32), .B_TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_msi_valid(msi_valid), .i_msi_addr(msi_addr), .i_msi_data(msi_data),
        .o_msi_ready(msi_ready), .o_msi_done(msi_done), .o_msi_err(msi_err),
        .o_aw_valid(aw_valid), .o_aw_addr(aw_addr), .i_aw_ready(aw_ready),
        .o_w_valid(w_valid), .o_w_data(w_data), .i_w_ready(w_ready),
        .i_b_valid(b_valid), .i_b_resp(b_resp), .o_b_ready(b_ready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        msi_valid = 2'b11;
        #1;
        n_cmp++;
        if ({msi_ready, aw_valid, w_valid, b_ready, busy, msi_done, msi_err} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 0", {msi_ready, aw_valid, w_valid, b_ready, busy, msi_done, msi_err});
        end
        msi_valid = 2'b00;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({b_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release got %b want 10", {b_ready, busy});
        end
    endtask

    task automatic test_single();
        msi_valid = 2'b10;
        msi_addr[64 +: 64] = 64'h2800_1000;
        msi_data[32 +: 32] = 32'h5;
        #1;
        n_cmp++;
        if (msi_ready !== 2'b10) begin
            n_err++;
            $display("FAIL single_ready got %b want 10", msi_ready);
        end
        tick();
        msi_valid = 2'b00;
        n_cmp++;
        if ({aw_valid, w_valid, aw_addr, w_data, b_ready, busy} !== {1'b1, 1'b1, 64'h2800_1000, 32'h5, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL single_bus got %b%b %h %h %b%b want 11 2800_1000 5 01", aw_valid, w_valid, aw_addr, w_data, b_ready, busy);
        end
        tick();
        n_cmp++;
        if ({aw_valid, w_valid, b_ready, busy} !== 4'b0011) begin
            n_err++;
            $display("FAIL single_waitb got %b want 0011", {aw_valid, w_valid, b_ready, busy});
        end
        b_valid = 1'b1;
        b_resp = 2'b00;
        tick();
        b_valid = 1'b0;
        n_cmp++;
        if ({msi_done, msi_err, busy} !== 5'b10000) begin
            n_err++;
            $display("FAIL single_done got %b want 10000", {msi_done, msi_err, busy});
        end
        tick();
        n_cmp++;
        if (msi_done !== 2'b00) begin
            n_err++;
            $display("FAIL single_done_pulse got %b want 00", msi_done);
        end
    endtask

    task automatic test_contention();
        msi_valid = 2'b11;
        msi_addr = {64'h2000, 64'h1000};
        msi_data = {32'hB, 32'hA};
        #1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  oh;
            logic [63:0] ea;
            oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            ea = (i % 2 == 0) ? 64'h1000 : 64'h2000;
            n_cmp++;
            if (msi_ready !== oh) begin
                n_err++;
                $display("FAIL rr_grant%0d got %b want %b", i, msi_ready, oh);
            end
            tick();
            n_cmp++;
            if ({msi_ready, aw_valid, aw_addr} !== {2'b00, 1'b1, ea}) begin
                n_err++;
                $display("FAIL rr_bus%0d got %b %b %h want 00 1 %h", i, msi_ready, aw_valid, aw_addr, ea);
            end
            tick();
            n_cmp++;
            if (msi_ready !== 2'b00) begin
                n_err++;
                $display("FAIL rr_nogrant%0d got %b want 00", i, msi_ready);
            end
            b_valid = 1'b1;
            tick();
            b_valid = 1'b0;
            n_cmp++;
            if ({msi_done, msi_err} !== {oh, 2'b00}) begin
                n_err++;
                $display("FAIL rr_done%0d got %b want %b00", i, {msi_done, msi_err}, oh);
            end
        end
        msi_valid = 2'b00;
    endtask

    task automatic test_split(input bit aw_slow);
        msi_valid = 2'b01;
        msi_addr[0 +: 64] = 64'h3000;
        msi_data[0 +: 32] = 32'hC;
        aw_ready = !aw_slow;
        w_ready = aw_slow;
        #1;
        n_cmp++;
        if (msi_ready !== 2'b01) begin
            n_err++;
            $display("FAIL split%0d_ready got %b want 01", aw_slow, msi_ready);
        end
        tick();
        msi_valid = 2'b00;
        n_cmp++;
        if ({aw_valid, w_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL split%0d_first got %b want 11", aw_slow, {aw_valid, w_valid});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (aw_slow ? ({aw_valid, w_valid, b_ready, aw_addr} !== {3'b100, 64'h3000})
                        : ({aw_valid, w_valid, b_ready, w_data} !== {3'b010, 32'hC})) begin
                n_err++;
                $display("FAIL split%0d_hold%0d got %b%b%b %h %h", aw_slow, k, aw_valid, w_valid, b_ready, aw_addr, w_data);
            end
        end
        aw_ready = 1'b1;
        w_ready = 1'b1;
        tick();
        n_cmp++;
        if ({aw_valid, w_valid, b_ready, busy} !== 4'b0011) begin
            n_err++;
            $display("FAIL split%0d_waitb got %b want 0011", aw_slow, {aw_valid, w_valid, b_ready, busy});
        end
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        n_cmp++;
        if ({msi_done, msi_err} !== 4'b0100) begin
            n_err++;
            $display("FAIL split%0d_done got %b want 0100", aw_slow, {msi_done, msi_err});
        end
    endtask

    task automatic test_error();
        msi_valid = 2'b10;
        msi_addr[64 +: 64] = 64'h4000;
        #1;
        n_cmp++;
        if (msi_ready !== 2'b10) begin
            n_err++;
            $display("FAIL err_ready got %b want 10", msi_ready);
        end
        tick();
        msi_valid = 2'b00;
        tick();
        b_valid = 1'b1;
        b_resp = 2'b10;
        tick();
        b_valid = 1'b0;
        b_resp = 2'b00;
        n_cmp++;
        if ({msi_done, msi_err} !== 4'b1010) begin
            n_err++;
            $display("FAIL err_pulse got %b want 1010", {msi_done, msi_err});
        end
    endtask

    task automatic test_timeout();
        msi_valid = 2'b01;
        #1;
        n_cmp++;
        if (msi_ready !== 2'b01) begin
            n_err++;
            $display("FAIL to_ready got %b want 01", msi_ready);
        end
        tick();
        msi_valid = 2'b00;
        for (int k = 2; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (k < 10 ? ({msi_done, busy} !== 3'b001) : ({msi_done, msi_err, busy} !== 5'b01010)) begin
                n_err++;
                $display("FAIL to_cycle%0d got done %b err %b busy %b", k, msi_done, msi_err, busy);
            end
        end
        tick();
        n_cmp++;
        if ({b_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL to_idle got %b want 10", {b_ready, busy});
        end
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({msi_done, msi_err, busy} !== 5'b0) begin
                n_err++;
                $display("FAIL to_late_b%0d got %b want 00000", k, {msi_done, msi_err, busy});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        aw_ready = 1'b0;
        w_ready = 1'b0;
        msi_valid = 2'b11;
        #1;
        n_cmp++;
        if (msi_ready !== 2'b10) begin
            n_err++;
            $display("FAIL rm_pre_grant got %b want 10", msi_ready);
        end
        tick();
        n_cmp++;
        if ({aw_valid, w_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL rm_send got %b want 11", {aw_valid, w_valid});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({msi_ready, aw_valid, w_valid, b_ready, busy, msi_done} !== 8'b0) begin
            n_err++;
            $display("FAIL rm_in_reset got %b want 0", {msi_ready, aw_valid, w_valid, b_ready, busy, msi_done});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({msi_ready, msi_done} !== 4'b0100) begin
            n_err++;
            $display("FAIL rm_first_grant got %b want 0100", {msi_ready, msi_done});
        end
        aw_ready = 1'b1;
        w_ready = 1'b1;
        tick();
        msi_valid = 2'b00;
        tick();
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        n_cmp++;
        if ({msi_done, msi_err} !== 4'b0100) begin
            n_err++;
            $display("FAIL rm_done got %b want 0100", {msi_done, msi_err});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_split(1'b1);
        test_split(1'b0);
        test_error();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
